// File: rtl/branch_resolver_pkg.sv
// Shared constants and types for the EX-stage branch resolver.
// Default widths and the redirect FSM state encoding.
package branch_resolver_pkg;

  localparam int DEF_WIDTH_PC  = 32;
  localparam int DEF_WIDTH_CNT = 32;

  typedef enum logic {
    BRS_IDLE     = 1'b0,
    BRS_REDIRECT = 1'b1
  } brs_state_t;

endpackage

// File: rtl/branch_resolver_if.sv
// EX-stage resolve bundle: EX inputs in, redirect/flush out.
// master = pipeline side, slave = branch_resolver.
interface branch_resolver_if #(
  parameter int WIDTH_PC = 32
);

  logic                ex_valid;
  logic                ex_is_branch;
  logic                ex_is_jal;
  logic                ex_is_jalr;
  logic [WIDTH_PC-1:0] ex_pc;
  logic [WIDTH_PC-1:0] ex_pred_pc;
  logic                ex_taken;
  logic [WIDTH_PC-1:0] ex_target;
  logic                stall;
  logic                redirect_valid;
  logic [WIDTH_PC-1:0] redirect_pc;
  logic                flush_if;
  logic                flush_id;
  logic                flush_ex;

  modport master (
    output ex_valid, ex_is_branch, ex_is_jal,
    output ex_is_jalr, ex_pc, ex_pred_pc,
    output ex_taken, ex_target, stall,
    input  redirect_valid, redirect_pc,
    input  flush_if, flush_id, flush_ex
  );

  modport slave (
    input  ex_valid, ex_is_branch, ex_is_jal,
    input  ex_is_jalr, ex_pc, ex_pred_pc,
    input  ex_taken, ex_target, stall,
    output redirect_valid, redirect_pc,
    output flush_if, flush_id, flush_ex
  );

endinterface

// File: rtl/branch_resolver_sat_counter.sv
// Saturating up-counter: +1 on inc, holds at all-ones.
// Ports: clk, rst_n (async low), inc, count.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: checks predicted next PC, issues redirect+flush.
// Ports: clk, rst_n, bus (slave), cnt_branch, cnt_mispredict.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int WIDTH_PC = DEF_WIDTH_PC,
  parameter int CNT_W    = DEF_WIDTH_CNT
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_resolver_if.slave bus,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_mispredict
);

  brs_state_t          state;
  logic                is_ctl;
  logic                res;
  logic                mis;
  logic [WIDTH_PC-1:0] seq_pc;
  logic [WIDTH_PC-1:0] actual;
  logic                rv_q;
  logic [WIDTH_PC-1:0] rpc_q;
  logic                flush_q;

  assign is_ctl = bus.ex_is_branch
                | bus.ex_is_jal
                | bus.ex_is_jalr;

  // Resolve only as the instruction leaves EX.
  assign res = bus.ex_valid & ~bus.stall
             & is_ctl & (state == BRS_IDLE);

  assign seq_pc = bus.ex_pc + WIDTH_PC'(4);

  always_comb begin
    actual = seq_pc;
    if (bus.ex_is_jal || bus.ex_is_jalr) begin
      actual = {bus.ex_target[WIDTH_PC-1:1], 1'b0};
    end else if (bus.ex_taken) begin
      actual = bus.ex_target;
    end
  end

  assign mis = res & (actual != bus.ex_pred_pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BRS_IDLE;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      unique case (state)
        BRS_IDLE: begin
          if (mis) begin
            state   <= BRS_REDIRECT;
            rv_q    <= 1'b1;
            rpc_q   <= actual;
            flush_q <= 1'b1;
          end
        end
        BRS_REDIRECT: begin
          // EX is wrong-path here; only stall matters.
          if (!bus.stall) begin
            state   <= BRS_IDLE;
            rv_q    <= 1'b0;
            flush_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.flush_if       = flush_q;
  assign bus.flush_id       = flush_q;
  assign bus.flush_ex       = flush_q;

  sat_counter #(.W(CNT_W)) u_cnt_branch (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (res),
    .count (cnt_branch)
  );

  sat_counter #(.W(CNT_W)) u_cnt_mis (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mis),
    .count (cnt_mispredict)
  );

endmodule
